led_matrix_capture: RTL and testbench

Receiving end of the 8x8 RGB LED matrix pin protocol: samples the six display pins (reset_out, OE, SH_CP, ST_CP, DS, col_select) driven by the matrix update logic and reconstructs the displayed image as three 8x8 bitplanes. It behaves as a behavioural model of the on-board 24-bit shift register, storage latch and column driver. It sits in loopback on the same clock as the display driver and serves as a self-check monitor in simulation and on hardware (frame readback, protocol error flags).

---
 rtl/led_matrix_capture.sv | 148 ++++++++++++++
 tb/tb_led_matrix_capture.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_matrix_capture.sv
// Loopback monitor for the 8x8 RGB matrix pin protocol. It rebuilds the displayed image
// from the shift/latch/enable pins and flags protocol errors.
module led_matrix_capture #(
  parameter bit INVERT_DATA = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            reset_out,
  input  logic            OE,
  input  logic            SH_CP,
  input  logic            ST_CP,
  input  logic            DS,
  input  logic [7:0]      col_select,
  output logic [0:7][7:0] frame_red,
  output logic [0:7][7:0] frame_green,
  output logic [0:7][7:0] frame_blue,
  output logic            frame_valid,
  output logic [15:0]     frame_count,
  output logic            bit_count_err,
  output logic            col_err,
  output logic            frame_err
);

  // Two-flop input stage. Edges are detected between the q and qq flops.
  logic rst_out_q, rst_out_qq, oe_q, oe_qq, sh_q, sh_qq, st_q, st_qq, ds_q;
  logic [7:0] col_q;

  logic [23:0]       shreg_q, shreg_d, latch_q, latch_d;
  logic [4:0]        cnt_q, cnt_d, cnt_shift;
  logic [0:7][23:0]  work_q, work_d, frame_q, frame_d;
  logic [7:0]        mask_q, mask_d;
  logic [15:0]       frame_count_q, frame_count_d;
  logic              valid_q, valid_d, bce_q, bce_d, cerr_q, cerr_d, ferr_q, ferr_d;

  logic       sh_rise, st_rise, oe_fall, onehot, commit;
  logic [2:0] col_idx;

  assign sh_rise = sh_q & ~sh_qq;
  assign st_rise = st_q & ~st_qq;
  assign oe_fall = ~oe_q & oe_qq;

  always_comb begin
    shreg_d   = shreg_q;
    cnt_shift = cnt_q;
    if (!rst_out_q) begin
      shreg_d   = '0;
      cnt_shift = '0;
    end else if (sh_rise) begin
      shreg_d   = {shreg_q[22:0], ds_q ^ INVERT_DATA};
      cnt_shift = (cnt_q == 5'd31) ? cnt_q : 5'(cnt_q + 5'd1);
    end
    // A same-cycle shift lands in the latch and counts toward the 24-bit check.
    latch_d = st_rise ? shreg_d : latch_q;
    cnt_d   = st_rise ? 5'd0 : cnt_shift;
    bce_d   = st_rise && (cnt_shift != 5'd24);
  end

  always_comb begin
    onehot  = (col_q != 8'd0) && ((col_q & 8'(col_q - 8'd1)) == 8'd0);
    col_idx = 3'd0;
    for (int i = 0; i < 8; i++)
      if (col_q[i]) col_idx = 3'(i);
    commit        = oe_fall && onehot;
    cerr_d        = oe_fall && !onehot;
    work_d        = work_q;
    mask_d        = mask_q;
    frame_d       = frame_q;
    frame_count_d = frame_count_q;
    valid_d       = 1'b0;
    ferr_d        = 1'b0;
    if (commit) begin
      work_d[col_idx] = latch_d;
      if (col_idx == 3'd7) begin
        mask_d = '0;
        if (mask_q[6:0] == 7'h7F) begin
          frame_d       = work_d;
          valid_d       = 1'b1;
          frame_count_d = frame_count_q + 16'd1;
        end else begin
          ferr_d = 1'b1;
        end
      end else begin
        mask_d[col_idx] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rst_out_q     <= 1'b0;
      rst_out_qq    <= 1'b0;
      oe_q          <= 1'b1;
      oe_qq         <= 1'b1;
      sh_q          <= 1'b0;
      sh_qq         <= 1'b0;
      st_q          <= 1'b0;
      st_qq         <= 1'b0;
      ds_q          <= 1'b0;
      col_q         <= '0;
      shreg_q       <= '0;
      latch_q       <= '0;
      cnt_q         <= '0;
      work_q        <= '0;
      mask_q        <= '0;
      frame_q       <= '0;
      frame_count_q <= '0;
      valid_q       <= 1'b0;
      bce_q         <= 1'b0;
      cerr_q        <= 1'b0;
      ferr_q        <= 1'b0;
    end else begin
      rst_out_q     <= reset_out;
      rst_out_qq    <= rst_out_q;
      oe_q          <= OE;
      oe_qq         <= oe_q;
      sh_q          <= SH_CP;
      sh_qq         <= sh_q;
      st_q          <= ST_CP;
      st_qq         <= st_q;
      ds_q          <= DS;
      col_q         <= col_select;
      shreg_q       <= shreg_d;
      latch_q       <= latch_d;
      cnt_q         <= cnt_d;
      work_q        <= work_d;
      mask_q        <= mask_d;
      frame_q       <= frame_d;
      frame_count_q <= frame_count_d;
      valid_q       <= valid_d;
      bce_q         <= bce_d;
      cerr_q        <= cerr_d;
      ferr_q        <= ferr_d;
    end
  end

  for (genvar c = 0; c < 8; c++) begin : g_col
    assign frame_red[c]   = frame_q[c][23:16];
    assign frame_green[c] = frame_q[c][15:8];
    assign frame_blue[c]  = frame_q[c][7:0];
  end

  assign frame_valid   = valid_q;
  assign frame_count   = frame_count_q;
  assign bit_count_err = bce_q;
  assign col_err       = cerr_q;
  assign frame_err     = ferr_q;

endmodule

// File: tb/tb_led_matrix_capture.sv
// Bench for led_matrix_capture. It drives pin-level frames and compares the DUT against a
// word/column-level model of the shift register, latch, commit mask and frame publishing.
module tb_led_matrix_capture;
  logic clk = 1'b0;
  logic reset, reset_out, OE, SH_CP, ST_CP, DS;
  logic [7:0] col_select;
  logic [0:7][7:0] frame_red, frame_green, frame_blue, i_red, i_green, i_blue;
  logic frame_valid, bit_count_err, col_err, frame_err;
  logic i_valid, i_bce, i_cerr, i_ferr;
  logic [15:0] frame_count, i_count;

  always #5 clk = ~clk;

  led_matrix_capture #(.INVERT_DATA(1'b0)) dut (
    .clk(clk), .reset(reset), .reset_out(reset_out), .OE(OE), .SH_CP(SH_CP), .ST_CP(ST_CP),
    .DS(DS), .col_select(col_select), .frame_red(frame_red), .frame_green(frame_green),
    .frame_blue(frame_blue), .frame_valid(frame_valid), .frame_count(frame_count),
    .bit_count_err(bit_count_err), .col_err(col_err), .frame_err(frame_err));

  led_matrix_capture #(.INVERT_DATA(1'b1)) dut_inv (
    .clk(clk), .reset(reset), .reset_out(reset_out), .OE(OE), .SH_CP(SH_CP), .ST_CP(ST_CP),
    .DS(DS), .col_select(col_select), .frame_red(i_red), .frame_green(i_green),
    .frame_blue(i_blue), .frame_valid(i_valid), .frame_count(i_count),
    .bit_count_err(i_bce), .col_err(i_cerr), .frame_err(i_ferr));

  int n_checks = 0, n_fail = 0;
  // Cycle-level pulse counts: a pulse wider than one cycle counts more than once.
  int n_valid = 0, n_bce = 0, n_ce = 0, n_fe = 0;
  int e_valid = 0, e_bce = 0, e_ce = 0, e_fe = 0;

  always @(negedge clk) begin
    if (frame_valid)   n_valid++;
    if (bit_count_err) n_bce++;
    if (col_err)       n_ce++;
    if (frame_err)     n_fe++;
  end

  // Reference model state
  logic [23:0] m_sh, m_latch;
  int          m_cnt;
  logic [23:0] m_work [8];
  logic [23:0] m_frame [8];
  logic [7:0]  m_mask;
  logic [15:0] m_count;

  task automatic model_reset();
    m_sh = '0; m_latch = '0; m_cnt = 0; m_mask = '0; m_count = '0;
    for (int c = 0; c < 8; c++) begin m_work[c] = '0; m_frame[c] = '0; end
  endtask

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; step(3); reset = 1'b0; step(2);
    model_reset();
  endtask

  task automatic shift_bit(logic b);
    DS = b; SH_CP = 1'b1; step(3); SH_CP = 1'b0; step(3);
    if (reset_out) begin
      m_sh = {m_sh[22:0], b};
      if (m_cnt < 31) m_cnt++;
    end
  endtask

  task automatic latch_pulse();
    ST_CP = 1'b1; step(3); ST_CP = 1'b0; step(3);
    m_latch = m_sh;
    if (m_cnt != 24) e_bce++;
    m_cnt = 0;
  endtask

  task automatic commit(logic [7:0] sel);
    col_select = sel; step(3); OE = 1'b0; step(3); OE = 1'b1; step(3);
    if ($countones(sel) == 1) begin
      int c = 0;
      for (int i = 0; i < 8; i++) if (sel[i]) c = i;
      m_work[c] = m_latch;
      if (c == 7) begin
        if (m_mask[6:0] == 7'h7F) begin
          for (int k = 0; k < 8; k++) m_frame[k] = m_work[k];
          m_count++; e_valid++;
        end else e_fe++;
        m_mask = '0;
      end else m_mask[c] = 1'b1;
    end else e_ce++;
  endtask

  task automatic send_word(logic [23:0] w, int nbits);
    for (int i = nbits - 1; i >= 0; i--) shift_bit(w[i]);
    latch_pulse();
  endtask

  task automatic test_reset();
    reset_out = 1'b1; OE = 1'b1; SH_CP = 1'b0; ST_CP = 1'b0; DS = 1'b0; col_select = '0;
    do_reset();
    n_checks++;
    if (frame_count !== 16'd0) begin $display("FAIL reset_count: got %h want 0000", frame_count); n_fail++; end
    n_checks++;
    if ({frame_valid, bit_count_err, col_err, frame_err} !== 4'b0) begin
      $display("FAIL reset_flags: got %b want 0000", {frame_valid, bit_count_err, col_err, frame_err}); n_fail++;
    end
    n_checks++;
    if ({frame_red, frame_green, frame_blue} !== '0) begin $display("FAIL reset_planes: got nonzero want 0"); n_fail++; end
  endtask

  task automatic test_full_frame();
    for (int c = 0; c < 8; c++) begin
      send_word({8'(8'h01 << c), 8'hA5, 8'h00}, 24);
      commit(8'(8'h01 << c));
    end
    for (int c = 0; c < 8; c++) begin
      n_checks++;
      if (frame_red[c] !== 8'(8'h01 << c) || frame_green[c] !== 8'hA5 || frame_blue[c] !== 8'h00) begin
        $display("FAIL full_col%0d: got %h_%h_%h want %h_a5_00", c, frame_red[c], frame_green[c], frame_blue[c], 8'(8'h01 << c));
        n_fail++;
      end
    end
    n_checks++;
    if (frame_count !== 16'd1 || n_valid !== 1) begin
      $display("FAIL full_count: got count %0d valid %0d want 1 1", frame_count, n_valid); n_fail++;
    end
    n_checks++;
    if (n_bce + n_ce + n_fe !== 0) begin $display("FAIL full_errors: got %0d want 0", n_bce + n_ce + n_fe); n_fail++; end
  endtask

  task automatic test_short_shift();
    send_word(24'($urandom), 23);
    commit(8'h01);
    for (int c = 1; c < 8; c++) begin send_word(24'($urandom), 24); commit(8'(8'h01 << c)); end
    n_checks++;
    if (n_bce !== e_bce) begin $display("FAIL short_bce: got %0d want %0d", n_bce, e_bce); n_fail++; end
    n_checks++;
    if ({frame_red[0], frame_green[0], frame_blue[0]} !== m_frame[0]) begin
      $display("FAIL short_col0: got %h want %h", {frame_red[0], frame_green[0], frame_blue[0]}, m_frame[0]); n_fail++;
    end
  endtask

  task automatic test_bad_column();
    logic [0:7][7:0] prev_red;
    prev_red = frame_red;
    for (int c = 0; c < 6; c++) begin send_word(24'($urandom), 24); commit(8'(8'h01 << c)); end
    send_word(24'($urandom), 24); commit(8'h03);
    commit(8'h00);
    send_word(24'($urandom), 24); commit(8'h80);
    n_checks++;
    if (n_ce !== e_ce || e_ce !== 2) begin $display("FAIL bad_col_err: got %0d want %0d", n_ce, e_ce); n_fail++; end
    n_checks++;
    if (n_fe !== e_fe || e_fe !== 1) begin $display("FAIL bad_frame_err: got %0d want %0d", n_fe, e_fe); n_fail++; end
    n_checks++;
    if (frame_red !== prev_red || frame_count !== m_count) begin
      $display("FAIL bad_unchanged: got count %0d want %0d", frame_count, m_count); n_fail++;
    end
  endtask

  task automatic test_reset_out();
    int bce0;
    bce0 = e_bce;
    for (int i = 0; i < 12; i++) shift_bit(1'($urandom));
    reset_out = 1'b0; step(3); m_sh = '0; m_cnt = 0;
    reset_out = 1'b1; step(3);
    send_word(24'hFF00FF, 24);
    commit(8'h08);
    for (int c = 0; c < 8; c++) if (c != 3) begin send_word(24'($urandom), 24); commit(8'(8'h01 << c)); end
    n_checks++;
    if ({frame_red[3], frame_green[3], frame_blue[3]} !== 24'hFF00FF) begin
      $display("FAIL rstout_col3: got %h want ff00ff", {frame_red[3], frame_green[3], frame_blue[3]}); n_fail++;
    end
    n_checks++;
    if (n_bce !== bce0) begin $display("FAIL rstout_bce: got %0d want %0d", n_bce, bce0); n_fail++; end
  endtask

  task automatic test_simultaneous();
    logic [23:0] w;
    logic b;
    w = 24'($urandom);
    for (int i = 23; i >= 1; i--) shift_bit(w[i]);
    b = w[0];
    DS = b; SH_CP = 1'b1; ST_CP = 1'b1; step(3); SH_CP = 1'b0; ST_CP = 1'b0; step(3);
    m_sh = {m_sh[22:0], b}; m_latch = m_sh; m_cnt = 0;
    commit(8'h20);
    for (int c = 0; c < 8; c++) if (c != 5) begin send_word(24'($urandom), 24); commit(8'(8'h01 << c)); end
    n_checks++;
    if ({frame_red[5], frame_green[5], frame_blue[5]} !== w) begin
      $display("FAIL simul_col5: got %h want %h", {frame_red[5], frame_green[5], frame_blue[5]}, w); n_fail++;
    end
    n_checks++;
    if (n_bce !== e_bce) begin $display("FAIL simul_bce: got %0d want %0d", n_bce, e_bce); n_fail++; end
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 3; f++) begin
      for (int c = 0; c < 8; c++) begin
        send_word(24'($urandom), 24); commit(8'(8'h01 << c));
        if (c < 7 && $urandom_range(0, 2) == 0) begin send_word(24'($urandom), 24); commit(8'(8'h01 << c)); end
      end
      for (int c = 0; c < 8; c++) begin
        n_checks++;
        if ({frame_red[c], frame_green[c], frame_blue[c]} !== m_frame[c]) begin
          $display("FAIL rand_f%0d_col%0d: got %h want %h", f, c, {frame_red[c], frame_green[c], frame_blue[c]}, m_frame[c]);
          n_fail++;
        end
      end
      n_checks++;
      if (frame_count !== m_count || n_valid !== e_valid) begin
        $display("FAIL rand_count: got %0d/%0d want %0d/%0d", frame_count, n_valid, m_count, e_valid); n_fail++;
      end
    end
  endtask

  task automatic test_invert();
    for (int c = 0; c < 8; c++) begin send_word(24'h000000, 24); commit(8'(8'h01 << c)); end
    n_checks++;
    if (i_red !== {8{8'hFF}} || i_green !== {8{8'hFF}} || i_blue !== {8{8'hFF}}) begin
      $display("FAIL invert_planes: got %h %h %h want all ff", i_red, i_green, i_blue); n_fail++;
    end
    n_checks++;
    if ({frame_red, frame_green, frame_blue} !== '0) begin $display("FAIL noinvert_planes: got nonzero want 0"); n_fail++; end
  endtask

  task automatic test_wrap();
    force dut.frame_count_q = 16'hFFFF;
    step(1);
    release dut.frame_count_q;
    m_count = 16'hFFFF;
    for (int c = 0; c < 8; c++) begin send_word(24'($urandom), 24); commit(8'(8'h01 << c)); end
    n_checks++;
    if (frame_count !== 16'h0000 || m_count !== 16'h0000) begin
      $display("FAIL wrap_count: got %h want 0000", frame_count); n_fail++;
    end
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 4; c++) begin send_word(24'($urandom), 24); commit(8'(8'h01 << c)); end
    do_reset();
    n_checks++;
    if ({frame_red, frame_green, frame_blue} !== '0 || frame_count !== 16'd0) begin
      $display("FAIL midrst_clear: got count %h want 0000 and zero planes", frame_count); n_fail++;
    end
    // Columns 4-7 alone must not publish after reset.
    for (int c = 4; c < 8; c++) begin send_word(24'($urandom), 24); commit(8'(8'h01 << c)); end
    n_checks++;
    if (frame_count !== 16'd0 || n_fe !== e_fe) begin
      $display("FAIL midrst_partial: got count %0d ferr %0d want 0 %0d", frame_count, n_fe, e_fe); n_fail++;
    end
    for (int c = 0; c < 8; c++) begin send_word(24'($urandom), 24); commit(8'(8'h01 << c)); end
    for (int c = 0; c < 8; c++) begin
      n_checks++;
      if ({frame_red[c], frame_green[c], frame_blue[c]} !== m_frame[c]) begin
        $display("FAIL midrst_col%0d: got %h want %h", c, {frame_red[c], frame_green[c], frame_blue[c]}, m_frame[c]);
        n_fail++;
      end
    end
    n_checks++;
    if (frame_count !== 16'd1 || n_valid !== e_valid) begin
      $display("FAIL midrst_count: got %0d/%0d want 1/%0d", frame_count, n_valid, e_valid); n_fail++;
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_short_shift();
    test_bad_column();
    test_reset_out();
    test_simultaneous();
    test_random_frames();
    test_invert();
    test_wrap();
    test_reset_mid();
    n_checks++;
    if (n_ce !== e_ce || n_fe !== e_fe || n_bce !== e_bce) begin
      $display("FAIL total_errors: got %0d/%0d/%0d want %0d/%0d/%0d", n_ce, n_fe, n_bce, e_ce, e_fe, e_bce); n_fail++;
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
